dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the single-cycle CPU's data port: serves `daddr`/`dwdata`/`mem_we`, and returns `drdata` combinationally in the same cycle. Sits between the CPU core and the rest of the SoC. Contains word-organised RAM with per-byte write enables and a small memory-mapped I/O window. The window holds a cycle counter, a scratch register and a byte console FIFO drained by an external consumer over a valid/ready handshake.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `daddr` in 32: byte address from CPU.
- `dwdata` in 32: write data, already lane-aligned by CPU.
- `mem_we` in 4: per-byte write enable; bit i writes `dwdata[8i+7:8i]`.
- `drdata` out 32: read data, combinational from `daddr`.
- `cons_valid` out 1: console FIFO non-empty.
- `cons_data` out 8: FIFO head byte.
- `cons_ready` in 1: consumer accepts head when `cons_valid`.

## Operation
- Decode on `daddr[31]`:
  - 0 selects RAM.
  - 1 selects MMIO.
  - `daddr[1:0]` is ignored everywhere; accesses are word-aligned.
- RAM:
  - Word index is `daddr[log2(MEM_WORDS)+1:2]`; higher bits are ignored, so addresses alias and wrap.
  - Asynchronous read.
  - Write on clk edge for each set `mem_we` bit.
  - No reset of contents.
- MMIO, decoded by `daddr[4:2]`:
  - 0 CYCLE (RO): 32-bit counter.
    - Increments every cycle after reset; wraps 0xFFFFFFFF→0.
    - Writes ignored.
  - 1 CONS_DATA (WO):
    - A write with `mem_we[0]`=1 pushes `dwdata[7:0]`.
    - Reads return 0.
  - 2 CONS_STATUS:
    - Read fields: bit0 full, bit1 empty, bit2 overflow (sticky), bits[11:8] occupancy count; others 0.
    - A write with `mem_we[0]`=1 and `dwdata[2]`=1 clears overflow (W1C). Other bits are ignored.
  - 3 SCRATCH (RW): 32-bit, byte-enable writes.
  - 4–7: read 0, writes ignored.
- Reads never have side effects; a read of CONS_DATA does not pop.
- FIFO push rules:
  - Push when not full: entry stored, count+1.
  - Push when full and no pop this cycle: byte dropped, overflow←1.
  - Push when full with simultaneous pop: push accepted, count unchanged, overflow unchanged.
- FIFO pop: occurs when `cons_valid && cons_ready`; head advances, count−1.
- Simultaneous push and pop when not empty and not full: count unchanged, both take effect.
- `cons_ready` while empty has no effect.
- Pointers wrap modulo `FIFO_DEPTH`.
- Overflow: set and W1C clear in the same cycle → set wins.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - CYCLE=0, SCRATCH=0, overflow=0.
  - FIFO empty, pointers 0.
  - `cons_valid`=0, `cons_data`=0.
  - `drdata` follows decode of current `daddr` (CYCLE reads 0 during reset).
- Read latency 0: `drdata` is valid in the same cycle as `daddr`.
- Write latency 1: a read of the same address in the following cycle returns the new value.
- CYCLE reads return the registered value, N cycles after reset release reads N.
- Push into empty FIFO: `cons_valid`=1 from the next cycle; no bypass.
- `cons_data` is stable while `cons_valid`=1 and `cons_ready`=0.
- Reset asserted mid-operation discards FIFO contents immediately; RAM is unaffected.

## Structure
- Package `dmem_pkg`:
  - MMIO offsets: CYCLE=3'd0, CONS_DATA=3'd1, CONS_STATUS=3'd2, SCRATCH=3'd3.
  - Status bit positions.
  - `MMIO_SEL` bit index (31).
- Sub-module `byte_fifo`:
  - Parameter DEPTH.
  - Ports: push, push_data, pop, head, count, full, empty; async active-low reset.
- Top level holds the RAM array, CYCLE, SCRATCH, overflow, the address decode and the `drdata` mux.

## Test plan
- RAM byte enables: write 0xAABBCCDD to 0x10 with `mem_we`=4'hF, then write 0x00000011 with `mem_we`=4'h1 → read 0x10 = 0xAABBCC11. Read 0x10+4·MEM_WORDS → same value (alias).
- Counter: release reset, wait 5 cycles → CYCLE read = 5. SCRATCH write `mem_we`=4'hC of 0x12345678 → SCRATCH read = 0x12340000.
- Console handshake: push 0x41,0x42 with `cons_ready`=0 → `cons_valid`=1 one cycle after first push, `cons_data`=0x41, status count=2. Assert `cons_ready` → 0x41 then 0x42 seen, then `cons_valid`=0, empty=1.
- Overflow: with `cons_ready`=0, push 9 bytes into FIFO_DEPTH=8 → full=1, overflow=1, 9th byte lost. Write status 0x4 → overflow=0. Push while full with `cons_ready`=1 → accepted, count stays 8, overflow stays 0.
- Reset mid-operation: FIFO holding 3 bytes, SCRATCH=0xFF, pull `reset` low asynchronously → `cons_valid`=0 and SCRATCH=0 immediately. RAM word written earlier still reads back after release.
- Unmapped MMIO: write 0xFFFFFFFF to 0x80000014 → read returns 0; all other registers unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - MMIO register offsets (word offset taken from daddr[4:2])
//   - CONS_STATUS field positions
//   - MMIO_SEL: the address bit that selects the MMIO window over RAM
//   - status_word(): packs the console status fields into a read word
package dmem_pkg;

    localparam int MMIO_SEL = 31;

    localparam logic [2:0] MMIO_CYCLE       = 3'd0;
    localparam logic [2:0] MMIO_CONS_DATA   = 3'd1;
    localparam logic [2:0] MMIO_CONS_STATUS = 3'd2;
    localparam logic [2:0] MMIO_SCRATCH     = 3'd3;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_W     = 4;

    function automatic logic [31:0] status_word(
        input logic                  full,
        input logic                  empty,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[STAT_FULL_BIT]                        = full;
        w[STAT_EMPTY_BIT]                       = empty;
        w[STAT_OVF_BIT]                         = ovf;
        w[STAT_CNT_LSB +: STAT_CNT_W]           = cnt;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with occupancy count.
//   clk        : clock, all updates on rising edge
//   reset      : asynchronous active-low reset (empties FIFO, pointers to 0)
//   push       : write push_data this cycle (accepted if not full, or if a
//                pop happens in the same cycle)
//   push_data  : byte to store
//   pop        : consume head this cycle (ignored while empty)
//   head       : current head byte, 0 while empty
//   count      : number of stored entries (0..DEPTH)
//   full/empty : occupancy flags
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic do_pop;
    logic do_push;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign count  = count_q;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, because the slot it needs is freed by that pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to 0 while empty so the output is clean during reset
    // and after draining, without resetting the storage array.
    assign head = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Storage is data only; it needs no reset because empty/count gate it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder for the single-cycle CPU.
//   clk        : clock, all state updates on rising edge
//   reset      : asynchronous active-low reset
//   daddr      : byte address; bit 31 selects MMIO, else RAM; [1:0] ignored
//   dwdata     : lane-aligned write data
//   mem_we     : per-byte write enables (bit i writes dwdata[8i+7:8i])
//   drdata     : combinational read data for daddr
//   cons_valid : console FIFO holds at least one byte
//   cons_data  : console FIFO head byte
//   cons_ready : consumer takes the head when cons_valid is high
// MMIO window (daddr[4:2]): 0 CYCLE (RO), 1 CONS_DATA (WO push),
// 2 CONS_STATUS (RO fields, W1C overflow), 3 SCRATCH (RW), 4-7 reserved.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] drdata,
    output logic        cons_valid,
    output logic [7:0]  cons_data,
    input  logic        cons_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Address decode
    logic          mmio_sel;
    logic [2:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          unused_addr_bits;

    assign mmio_sel = daddr[MMIO_SEL];
    assign mmio_off = daddr[4:2];
    assign ram_idx  = daddr[AW+1:2];

    // Bits above the RAM index (below the select bit) and the byte offset
    // play no part in decode; RAM addresses alias across them.
    assign unused_addr_bits = ^{daddr[30:AW+2], daddr[1:0]};

    logic [3:0] ram_we;
    logic [3:0] scratch_we;
    logic       cons_push;
    logic       ovf_clr;

    assign ram_we     = mmio_sel ? 4'h0 : mem_we;
    assign scratch_we = (mmio_sel && (mmio_off == MMIO_SCRATCH)) ? mem_we : 4'h0;
    assign cons_push  = mmio_sel && (mmio_off == MMIO_CONS_DATA) && mem_we[0];
    assign ovf_clr    = mmio_sel && (mmio_off == MMIO_CONS_STATUS) && mem_we[0]
                        && dwdata[STAT_OVF_BIT];

    // RAM: asynchronous read, byte-enabled synchronous write, no reset.
    logic [31:0] ram [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) begin
                ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    // Console FIFO
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cons_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cons_push),
        .push_data (dwdata[7:0]),
        .pop       (cons_ready),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cons_valid = !fifo_empty;
    assign cons_data  = fifo_head;

    // A push is dropped only when full and the head is not leaving this
    // cycle; a full FIFO is never empty, so cons_ready alone tells us that.
    logic ovf_set;
    assign ovf_set = cons_push && fifo_full && !cons_ready;

    // Control and MMIO registers
    logic [31:0] cycle_q;
    logic [31:0] scratch_q;
    logic        ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            for (int i = 0; i < 4; i++) begin
                if (scratch_we[i]) begin
                    scratch_q[8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
            // A new overflow in the same cycle as a clear must not be lost.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Status count field is fixed-width; a deeper FIFO would truncate here.
    logic [STAT_CNT_W-1:0] stat_cnt;
    assign stat_cnt = STAT_CNT_W'(fifo_count);

    // Read mux: side-effect free, purely a function of daddr and state.
    always_comb begin
        drdata = '0;
        if (!mmio_sel) begin
            drdata = ram[ram_idx];
        end else begin
            case (mmio_off)
                MMIO_CYCLE:       drdata = cycle_q;
                MMIO_CONS_STATUS: drdata = status_word(fifo_full, fifo_empty, ovf_q, stat_cnt);
                MMIO_SCRATCH:     drdata = scratch_q;
                default:          drdata = '0;
            endcase
        end
    end

endmodule
